// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry defaults, quadrant and detector FSM types
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    Q_LT = 2'd0,
    Q_RT = 2'd1,
    Q_LB = 2'd2,
    Q_RB = 2'd3
  } quad_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    LATCH    = 2'd2
  } qcd_state_t;

  // Quadrant index from the two half-screen decisions: bit 1 = bottom, bit 0 = right.
  function automatic quad_t quad_of(input logic right, input logic bottom);
    return quad_t'({bottom, right});
  endfunction

endpackage

// File: rtl/rgb565_window_match.sv
// rtl/rgb565_window_match.sv - RGB565 channel split and inclusive colour-window compare
module rgb565_window_match (
  input  logic [15:0] pixel_i,
  input  logic [4:0]  r_min_i,
  input  logic [4:0]  r_max_i,
  input  logic [5:0]  g_min_i,
  input  logic [5:0]  g_max_i,
  input  logic [4:0]  b_min_i,
  input  logic [4:0]  b_max_i,
  output logic        hit_o
);

  logic [4:0] r;
  logic [5:0] g;
  logic [4:0] b;

  assign r = pixel_i[15:11];
  assign g = pixel_i[10:5];
  assign b = pixel_i[4:0];

  // A channel whose min exceeds its max can never satisfy both bounds, so it matches nothing.
  always_comb begin
    hit_o = (r >= r_min_i) && (r <= r_max_i) &&
            (g >= g_min_i) && (g <= g_max_i) &&
            (b >= b_min_i) && (b <= b_max_i);
  end

endmodule

// File: rtl/quadrant_color_detector.sv
// rtl/quadrant_color_detector.sv - per-quadrant colour-match counter with frame-rate detect flags; QCD_HYST_EN adds release hysteresis
module quadrant_color_detector
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned THRESH_ON = 2000
`ifdef QCD_HYST_EN
  ,
  parameter int unsigned HYST      = 500
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        de,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [15:0] pixel,
  input  logic [4:0]  r_min,
  input  logic [4:0]  r_max,
  input  logic [5:0]  g_min,
  input  logic [5:0]  g_max,
  input  logic [4:0]  b_min,
  input  logic [4:0]  b_max,
  output logic        detect_LT,
  output logic        detect_RT,
  output logic        detect_LB,
  output logic        detect_RB,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH_ON   = CNT_W'(THRESH_ON);
`ifdef QCD_HYST_EN
  localparam logic [CNT_W-1:0] TH_OFF  = CNT_W'(THRESH_ON - HYST);
`endif

  logic             win_hit;
  logic             in_range;
  logic             match_d, match_q;
  quad_t            quad_d, quad_q;
  logic             vsync_q;
  logic             vs_rise;
  qcd_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       detect_d, detect_q;
  logic             frame_done_d, frame_done_q;

  rgb565_window_match u_window (
    .pixel_i (pixel),
    .r_min_i (r_min),
    .r_max_i (r_max),
    .g_min_i (g_min),
    .g_max_i (g_max),
    .b_min_i (b_min),
    .b_max_i (b_max),
    .hit_o   (win_hit)
  );

  assign in_range = (x < 10'(H_ACTIVE)) && (y < 9'(V_ACTIVE));
  assign vs_rise  = vsync & ~vsync_q;

  // Stage 1 inputs: qualified match and the quadrant the pixel falls in.
  always_comb begin
    match_d = de & in_range & win_hit;
    quad_d  = quad_of(x >= 10'(H_ACTIVE / 2), y >= 9'(V_ACTIVE / 2));
  end

  // Stage 1 pipeline registers and the single-flop vsync edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
      quad_q  <= Q_LT;
      vsync_q <= 1'b0;
    end else begin
      match_q <= match_d;
      quad_q  <= quad_d;
      vsync_q <= vsync;
    end
  end

  // Frame FSM next state: first rise starts a clean frame, later rises close one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: if (vs_rise) state_d = ACCUM;
      ACCUM:    if (vs_rise) state_d = LATCH;
      LATCH:    state_d = ACCUM;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // Stage 2: saturating per-quadrant accumulate; the match in stage 2 on the rise cycle still lands in the closing frame.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == ACCUM) begin
        if (match_q && (quad_q == quad_t'(i[1:0])) && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Flag evaluation happens only in LATCH so the outputs hold for the whole following frame.
  always_comb begin
    detect_d     = detect_q;
    frame_done_d = 1'b0;
    if (state_q == LATCH) begin
      frame_done_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef QCD_HYST_EN
        if (cnt_q[i] >= TH_ON) begin
          detect_d[i] = 1'b1;
        end else if (cnt_q[i] < TH_OFF) begin
          detect_d[i] = 1'b0;
        end
`else
        detect_d[i] = (cnt_q[i] >= TH_ON);
`endif
      end
    end
  end

  // State, counters and output flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_SOF;
      detect_q     <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      detect_q     <= detect_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign detect_LT  = detect_q[Q_LT];
  assign detect_RT  = detect_q[Q_RT];
  assign detect_LB  = detect_q[Q_LB];
  assign detect_RB  = detect_q[Q_RB];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_quadrant_color_detector.sv
// tb/tb_quadrant_color_detector.sv - directed self-checking bench for quadrant_color_detector
module tb_quadrant_color_detector;

  localparam int CNT_W = 12;

  localparam logic [15:0] PIX_HIT    = {5'd15, 6'd30, 5'd10};
  localparam logic [15:0] PIX_LO     = {5'd10, 6'd20, 5'd5};
  localparam logic [15:0] PIX_HI     = {5'd20, 6'd40, 5'd15};
  localparam logic [15:0] PIX_MISS_R = {5'd21, 6'd30, 5'd10};
  localparam logic [15:0] PIX_MISS_G = {5'd15, 6'd19, 5'd10};

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [15:0] pixel;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;
  logic        detect_LT, detect_RT, detect_LB, detect_RB, frame_done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  quadrant_color_detector #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .pixel      (pixel),
    .r_min      (r_min),
    .r_max      (r_max),
    .g_min      (g_min),
    .g_max      (g_max),
    .b_min      (b_min),
    .b_max      (b_max),
    .detect_LT  (detect_LT),
    .detect_RT  (detect_RT),
    .detect_LB  (detect_LB),
    .detect_RB  (detect_RB),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {detect_RB, detect_LB, detect_RT, detect_LT};
  endfunction

  task automatic send(input int n, input int xx, input int yy, input logic dd, input logic [15:0] pix);
    for (int k = 0; k < n; k++) begin
      de    = dd;
      x     = 10'(xx);
      y     = 9'(yy);
      pixel = pix;
      tick();
    end
    de = 1'b0;
  endtask

  task automatic frame_end(input string tag, input int exp_done, input logic [3:0] exp_flags,
                           input logic de_on_rise);
    int done_seen;
    done_seen = 0;
    vsync = 1'b1;
    de    = de_on_rise;
    x     = 10'd10;
    y     = 9'd10;
    pixel = PIX_HIT;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (frame_done) done_seen++;
      de = 1'b0;
      if (k == 2) vsync = 1'b0;
    end
    check({tag, "_done"}, done_seen, exp_done);
    check({tag, "_flags"}, flags(), exp_flags);
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b0;
    de    = 1'b0;
    x     = '0;
    y     = '0;
    pixel = '0;
    r_min = 5'd10; r_max = 5'd20;
    g_min = 6'd20; g_max = 6'd40;
    b_min = 5'd5;  b_max = 5'd15;
    tick();
    tick();
    check("reset_outputs", {flags(), frame_done}, 5'b0);
    reset = 1'b0;
    tick();

    // Partial frame before the first vsync is discarded.
    send(3000, 600, 10, 1'b1, PIX_HIT);
    frame_end("t1_sof", 0, 4'b0000, 1'b0);
    send(1500, 5, 5, 1'b1, PIX_LO);
    send(1500, 300, 200, 1'b1, PIX_HI);
    frame_end("t1_lt", 1, 4'b0001, 1'b0);

    // Quadrant boundaries at x=319/320, y=239/240.
    send(2000, 319, 239, 1'b1, PIX_HIT);
    send(2000, 320, 239, 1'b1, PIX_HIT);
    send(2000, 319, 240, 1'b1, PIX_HIT);
    send(2000, 320, 240, 1'b1, PIX_HIT);
    frame_end("t2_bound", 1, 4'b1111, 1'b0);

    // Threshold edge: 1999 misses, 2000 hits; last RB pixel sits in stage 2 at the rise.
    send(1999, 0, 0, 1'b1, PIX_HIT);
    send(2000, 639, 0, 1'b1, PIX_HIT);
    send(2000, 639, 479, 1'b1, PIX_HIT);
    frame_end("t2_thresh", 1, 4'b1010, 1'b0);

    // Out-of-range, de=0, off-window and empty-window pixels are never counted.
    send(2500, 700, 10, 1'b1, PIX_HIT);
    send(2500, 10, 480, 1'b1, PIX_HIT);
    send(2500, 10, 10, 1'b0, PIX_HIT);
    send(2500, 400, 10, 1'b1, PIX_MISS_R);
    send(2500, 10, 300, 1'b1, PIX_MISS_G);
    r_min = 5'd20; r_max = 5'd10;
    send(2500, 400, 300, 1'b1, PIX_HIT);
    r_min = 5'd10; r_max = 5'd20;
    frame_end("t3_reject", 1, 4'b0000, 1'b0);

    // Saturation: 2^CNT_W+10 matches must pin the counter at all-ones.
    send(4106, 400, 300, 1'b1, PIX_HIT);
    tick();
    tick();
    check("t4_sat_count", dut.cnt_q[3], 32'hFFF);
    frame_end("t4_sat", 1, 4'b1000, 1'b0);

    // Counts 2100, 1800, 1400 in LT.
    send(2100, 100, 100, 1'b1, PIX_HIT);
    frame_end("t5_f1", 1, 4'b0001, 1'b0);
    send(1800, 100, 100, 1'b1, PIX_HIT);
`ifdef QCD_HYST_EN
    frame_end("t5_f2", 1, 4'b0001, 1'b0);
`else
    frame_end("t5_f2", 1, 4'b0000, 1'b0);
`endif
    send(1400, 100, 100, 1'b1, PIX_HIT);
    frame_end("t5_f3", 1, 4'b0000, 1'b0);

    // A pixel presented on the vsync-rise cycle reaches stage 2 in LATCH and is dropped.
    send(1999, 10, 10, 1'b1, PIX_HIT);
    frame_end("t5_drop", 1, 4'b0000, 1'b1);

    // Reset mid-frame clears flags at once; flags return only after a full frame.
    send(2500, 10, 10, 1'b1, PIX_HIT);
    frame_end("t6_pre", 1, 4'b0001, 1'b0);
    send(2500, 10, 10, 1'b1, PIX_HIT);
    reset = 1'b1;
    #1;
    check("t6_rst_flags", {flags(), frame_done}, 5'b0);
    tick();
    reset = 1'b0;
    tick();
    send(2500, 10, 10, 1'b1, PIX_HIT);
    frame_end("t6_sof", 0, 4'b0000, 1'b0);
    send(2500, 10, 10, 1'b1, PIX_HIT);
    frame_end("t6_post", 1, 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
